// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_pkg
// Brief    : Shared types, colour constants, win-line table and board helpers
//            for the tic-tac-toe board controller.
// Revision : 1.0
// ============================================================================
package board_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_X     = 2'd1,
        CELL_O     = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_UP    = 3'd1,
        ACT_DOWN  = 3'd2,
        ACT_LEFT  = 3'd3,
        ACT_RIGHT = 3'd4,
        ACT_SEL   = 3'd5
    } action_t;

    // Cell i sits at row i/3, column i%3.
    typedef logic [8:0][1:0] board_t;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [2:0] blue;
    } color_t;

    localparam logic [2:0] c_full = 3'b111;
    localparam logic [2:0] c_zero = 3'b000;

    localparam color_t c_black  = '{red: c_zero, green: c_zero, blue: c_zero};
    localparam color_t c_white  = '{red: c_full, green: c_full, blue: c_full};
    localparam color_t c_red    = '{red: c_full, green: c_zero, blue: c_zero};
    localparam color_t c_blue   = '{red: c_zero, green: c_zero, blue: c_full};
    localparam color_t c_yellow = '{red: c_full, green: c_full, blue: c_zero};

    // Rows, then columns, then the two diagonals.
    localparam logic [3:0] c_win_lines [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

    function automatic cell_t line_owner(input board_t board, input logic [2:0] line);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        a = board[c_win_lines[line][0]];
        b = board[c_win_lines[line][1]];
        c = board[c_win_lines[line][2]];
        if (a != CELL_EMPTY && a == b && b == c) begin
            return cell_t'(a);
        end
        return CELL_EMPTY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : board_ctrl_if
// Brief    : Button, pixel-coordinate and status/colour bundle of board_ctrl.
// Revision : 1.0
// ============================================================================
interface board_ctrl_if;

    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_sel;
    logic [15:0] h_count;
    logic [15:0] v_count;
    logic [2:0]  color_red;
    logic [2:0]  color_green;
    logic [2:0]  color_blue;
    logic        turn;
    logic [1:0]  winner;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_sel,
        output h_count, v_count,
        input  color_red, color_green, color_blue, turn, winner
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_sel,
        input  h_count, v_count,
        output color_red, color_green, color_blue, turn, winner
    );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-FF synchronizer, stability counter and one-cycle pulse on each
//            accepted rising edge of a raw push button.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  btn_in,
    output logic pulse
);

    localparam int unsigned c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               stable_q, stable_d;
    logic               pulse_q, pulse_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any bounce back restarts it from zero.
    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == c_cnt_last) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/board_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : board_ctrl
// Brief    : Tic-tac-toe controller: debounced buttons, wrapping cursor,
//            PLAY/CHECK/DONE game FSM and registered 3x3 grid renderer.
//            Define BOARD_CTRL_WIN_BLINK_EN to blink the winning line.
// Revision : 1.0
// ============================================================================
module board_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic [15:0] H_DIV1          = 16'd213,
    parameter logic [15:0] H_DIV2          = 16'd426,
    parameter logic [15:0] V_DIV1          = 16'd160,
    parameter logic [15:0] V_DIV2          = 16'd320
) (
    input  wire         clk,
    input  wire         rst_n,
    board_ctrl_if.slave bus
);

    import board_pkg::*;

    state_t     state_q, state_d;
    board_t     board_q, board_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic       turn_q, turn_d;
    logic [1:0] winner_q, winner_d;
    color_t     color_q, color_d;

    logic [4:0] btn_raw;
    logic [4:0] btn_pulse;
    action_t    action;
    logic [3:0] cur_idx;
    logic       sel_ok;
    logic       win_found;
    cell_t      win_mark;
    logic       board_full;
    logic [1:0] pix_row;
    logic [1:0] pix_col;
    logic [3:0] pix_idx;
    logic       blink_off;

    assign btn_raw = {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_in(btn_raw[i]),
            .pulse (btn_pulse[i])
        );
    end

    // Lowest bit (up) has highest priority; CHECK swallows every pulse.
    always_comb begin
        action = ACT_NONE;
        if (state_q != CHECK) begin
            if      (btn_pulse[0]) action = ACT_UP;
            else if (btn_pulse[1]) action = ACT_DOWN;
            else if (btn_pulse[2]) action = ACT_LEFT;
            else if (btn_pulse[3]) action = ACT_RIGHT;
            else if (btn_pulse[4]) action = ACT_SEL;
        end
    end

    assign cur_idx = cell_index(row_q, col_q);
    assign sel_ok  = (action == ACT_SEL) && (board_q[cur_idx] == CELL_EMPTY);

    always_comb begin
        win_found = 1'b0;
        win_mark  = CELL_EMPTY;
        for (int i = 0; i < 8; i++) begin
            if (!win_found && line_owner(board_q, 3'(i)) != CELL_EMPTY) begin
                win_found = 1'b1;
                win_mark  = line_owner(board_q, 3'(i));
            end
        end
        board_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board_q[i] == CELL_EMPTY) board_full = 1'b0;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= PLAY;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY:    if (sel_ok) state_d = CHECK;
            CHECK:   state_d = (win_found || board_full) ? DONE : PLAY;
            DONE:    if (action == ACT_SEL) state_d = PLAY;
            default: state_d = PLAY;
        endcase
    end

    // ---------------- FSM: board, cursor and result ----------------
    always_comb begin
        board_d  = board_q;
        row_d    = row_q;
        col_d    = col_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        case (state_q)
            PLAY: begin
                case (action)
                    ACT_UP:    row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
                    ACT_DOWN:  row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
                    ACT_LEFT:  col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
                    ACT_RIGHT: col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
                    ACT_SEL: begin
                        if (sel_ok) begin
                            board_d[cur_idx] = turn_q ? CELL_O : CELL_X;
                            turn_d           = ~turn_q;
                        end
                    end
                    default: ;
                endcase
            end
            CHECK: begin
                if (win_found)       winner_d = win_mark;
                else if (board_full) winner_d = 2'd3;
            end
            DONE: begin
                if (action == ACT_SEL) begin
                    board_d  = '0;
                    turn_d   = 1'b0;
                    winner_d = 2'd0;
                end
            end
            default: ;
        endcase
    end

    // ---------------- Pixel renderer ----------------
    always_comb begin
        pix_row = 2'd2;
        if      (bus.v_count < V_DIV1) pix_row = 2'd0;
        else if (bus.v_count < V_DIV2) pix_row = 2'd1;
        pix_col = 2'd2;
        if      (bus.h_count < H_DIV1) pix_col = 2'd0;
        else if (bus.h_count < H_DIV2) pix_col = 2'd1;
        pix_idx = cell_index(pix_row, pix_col);

        color_d = c_white;
        if (bus.h_count >= 16'd640 || bus.v_count >= 16'd480) begin
            color_d = c_black;
        end else if (bus.h_count == H_DIV1 || bus.h_count == H_DIV2 ||
                     bus.v_count == V_DIV1 || bus.v_count == V_DIV2) begin
            color_d = c_black;
        end else if (pix_idx == cur_idx) begin
            color_d = c_yellow;
        end else if (board_q[pix_idx] == CELL_X) begin
            color_d = blink_off ? c_black : c_red;
        end else if (board_q[pix_idx] == CELL_O) begin
            color_d = blink_off ? c_black : c_blue;
        end
    end

`ifdef BOARD_CTRL_WIN_BLINK_EN
    logic [5:0] frame_q, frame_d;
    logic       v_zero_q;
    logic [8:0] win_mask_q, win_mask_d;

    // Descending scan so the lowest-numbered complete line is latched,
    // matching the mark reported on winner.
    always_comb begin
        frame_d = frame_q;
        if (bus.v_count == 16'd0 && !v_zero_q) frame_d = frame_q + 6'd1;
        win_mask_d = win_mask_q;
        if (state_q == CHECK) begin
            for (int i = 7; i >= 0; i--) begin
                if (line_owner(board_q, 3'(i)) != CELL_EMPTY) begin
                    win_mask_d = '0;
                    for (int k = 0; k < 3; k++) win_mask_d[c_win_lines[i][k]] = 1'b1;
                end
            end
        end else if (state_q == DONE && action == ACT_SEL) begin
            win_mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q    <= '0;
            v_zero_q   <= 1'b0;
            win_mask_q <= '0;
        end else begin
            frame_q    <= frame_d;
            v_zero_q   <= (bus.v_count == 16'd0);
            win_mask_q <= win_mask_d;
        end
    end

    assign blink_off = win_mask_q[pix_idx] && frame_q[5];
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            board_q  <= '0;
            row_q    <= 2'd1;
            col_q    <= 2'd1;
            turn_q   <= 1'b0;
            winner_q <= 2'd0;
            color_q  <= c_black;
        end else begin
            board_q  <= board_d;
            row_q    <= row_d;
            col_q    <= col_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            color_q  <= color_d;
        end
    end

    assign bus.color_red   = color_q.red;
    assign bus.color_green = color_q.green;
    assign bus.color_blue  = color_q.blue;
    assign bus.turn        = turn_q;
    assign bus.winner      = winner_q;

endmodule
`default_nettype wire

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of stable clk cycles a button must hold before it is accepted (10 ms at 25 MHz).
REQ-002 Parameters H_DIV1/H_DIV2, default 213/426, are the grid column boundary pixels.
REQ-003 Parameters V_DIV1/V_DIV2, default 160/320, are the grid row boundary pixels.
REQ-004 clk  in  1  pixel clock (25 MHz); the block uses one clock, and reset is synchronous and active-low.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  raw asynchronous active-high buttons.
REQ-007 h_count, v_count  in  16 each  current pixel coordinates from the VGA timing block.
REQ-008 color_red, color_green, color_blue  out  3 each  color codes for the 3-bit-to-8-bit decoders.
REQ-009 turn  out  1  player to move next: 0 = X, 1 = O.
REQ-010 winner  out  2  game result: 0 = none, 1 = X, 2 = O, 3 = draw.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer, then a debounce counter; one press SHALL produce exactly one 1-cycle pulse on the accepted rising edge.
REQ-012 Pulses in the same cycle SHALL be resolved by priority up > down > left > right > sel, and only one action SHALL be taken per cycle.
REQ-013 The cursor row and column SHALL each be 0..2 and wrap: up from row 0 goes to row 2, right from col 2 goes to col 0, and so on.
REQ-014 The board SHALL be 9 cells of 2 bits each: EMPTY=0, X=1, O=2.
REQ-015 FSM states are PLAY, CHECK, DONE.
REQ-016 In PLAY, sel on an empty cell SHALL write the current player's mark, toggle turn, and enter CHECK on the next cycle.
REQ-017 In PLAY, sel on an occupied cell SHALL be ignored: no write, no turn change.
REQ-018 In CHECK, the FSM SHALL spend exactly 1 cycle evaluating all 8 lines.
REQ-019 CHECK SHALL transition as follows:
- a complete line goes to DONE with winner = that mark;
- otherwise, 9 filled cells goes to DONE with winner = 3;
- otherwise, back to PLAY.
REQ-020 In DONE, movement and board writes SHALL be ignored, and sel SHALL clear the board, set turn = 0 and winner = 0, and enter PLAY.
REQ-021 Button pulses arriving during CHECK SHALL be discarded.
REQ-022 Pixel color SHALL be registered with 1-cycle latency from h_count/v_count, using this priority:
- outside 640x480: black;
- h or v on a divider: black;
- cursor cell: yellow;
- X cell: red;
- O cell: blue;
- empty cell: white.
REQ-023 Color codes SHALL be full scale 3'b111 and zero 3'b000 per channel (yellow = R7 G7 B0).

Reset
REQ-024 With rst_n = 0 at a clk edge, the block SHALL reset to:
- board all EMPTY;
- cursor (1,1);
- turn 0, winner 0, state PLAY;
- debounce counters and synchronizers 0;
- color outputs 0.
REQ-025 Reset asserted mid-debounce or in CHECK/DONE SHALL abort the operation with no residual pulse after release.

Configuration
REQ-026 With BOARD_CTRL_WIN_BLINK_EN defined, the block SHALL latch the winning line's 3 cells on entry to DONE (wins only, not draws).
REQ-027 With BOARD_CTRL_WIN_BLINK_EN defined, the latched cells SHALL alternate between their mark color and black every 32 frames, where a frame is counted when v_count wraps to 0.
REQ-028 Without BOARD_CTRL_WIN_BLINK_EN, winning cells SHALL render statically, and no frame counter or line latch SHALL exist.

Structure
REQ-029 Package board_pkg SHALL hold:
- cell_t (EMPTY, X, O) and state_t (PLAY, CHECK, DONE);
- 3-bit color constants;
- the 8 win-line index triples.
REQ-030 Sub-module btn_debounce (synchronizer, counter, edge pulse) SHALL be instantiated 5 times, one per button.

Verification
REQ-031 With DEBOUNCE_CYCLES = 4, hold btn_right for 10 cycles -> exactly one pulse, cursor (1,1) -> (1,2); a 2-cycle glitch -> no move.
REQ-032 Cursor at (0,0), press up then left -> cursor (2,2).
REQ-033 Play X at (0,0), (0,1), (0,2) with O at (1,0), (1,1) -> winner = 1 one cycle after the 5th sel; further moves and selects are ignored.
REQ-034 sel twice on the same cell -> second press ignored, turn unchanged.
REQ-035 Fill 9 cells with no line -> winner = 3; sel in DONE -> board clear, turn 0, winner 0.
REQ-036 h = 213 or v = 320 -> black one cycle later; pixel (300,200) with cursor (1,1) -> yellow; pulse rst_n low mid-game -> all outputs at reset values.
